// File: rtl/mems_dac_ctrl.sv
// MEMS mirror DAC sequencer: initialises the DAC over an SPI master, then streams
// each accepted (x, y) deflection as four differential-pair DAC writes.
module mems_dac_ctrl #(
  parameter logic [15:0] BIAS    = 16'h8000,
  parameter logic [23:0] INIT0   = 24'h280001,
  parameter logic [23:0] INIT1   = 24'h380001,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic        pos_valid,
  output logic        pos_ready,
  output logic [23:0] spi_data,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic        init_done,
  output logic        frame_done,
  output logic        fault,
  output logic        busy
);

  // Timer only ever holds 0..TIMEOUT-1; the TIMEOUT-th cycle becomes the fault.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT_SEND,
    S_INIT_WAIT,
    S_READY,
    S_FR_SEND,
    S_FR_WAIT,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              spi_start_q, spi_start_d;
  logic [23:0]       spi_data_q, spi_data_d;
  logic              init_done_q, init_done_d;
  logic              frame_done_q, frame_done_d;
  logic              fault_q, fault_d;
  logic [3:0][15:0]  code_q, code_d;
  logic [3:0][15:0]  code_new;
  logic              accept;

  // Codes 0..3 are BIAS+x, BIAS-x, BIAS+y, BIAS-y, saturated to the DAC range.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_code
      logic signed [17:0] operand;
      logic signed [17:0] sum;
      assign operand = (gi < 2) ? {{2{x_in[15]}}, x_in} : {{2{y_in[15]}}, y_in};
      assign sum = (gi % 2 == 0) ? ($signed({2'b00, BIAS}) + operand)
                                 : ($signed({2'b00, BIAS}) - operand);
      assign code_new[gi] = sum[17] ? 16'h0000 : (sum[16] ? 16'hFFFF : sum[15:0]);
    end
  endgenerate

  function automatic logic [23:0] frame_word(input logic [1:0] i, input logic [15:0] d);
    logic [2:0] cmd;
    cmd = (i == 2'd3) ? 3'b010 : 3'b000;
    return {2'b00, cmd, 1'b0, i, d};
  endfunction

  assign pos_ready  = (state_q == S_READY) & enable & init_done_q & ~fault_q;
  assign accept     = pos_valid & pos_ready;
  assign spi_start  = spi_start_q;
  assign spi_data   = spi_data_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
  assign fault      = fault_q;
  assign busy       = (state_q != S_READY) && (state_q != S_FAULT);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    spi_start_d  = 1'b0;
    spi_data_d   = spi_data_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    fault_d      = fault_q;
    code_d       = code_q;

    case (state_q)
      S_INIT_SEND: begin
        if (!spi_busy) begin
          spi_start_d = 1'b1;
          spi_data_d  = idx_q[0] ? INIT1 : INIT0;
          timer_d     = '0;
          state_d     = S_INIT_WAIT;
        end
      end
      S_INIT_WAIT, S_FR_WAIT: begin
        // A done landing on the last timer cycle still wins over the timeout.
        if (spi_done) begin
          if (state_q == S_INIT_WAIT && idx_q == 2'd1) begin
            idx_d       = '0;
            init_done_d = 1'b1;
            state_d     = S_READY;
          end else if (state_q == S_FR_WAIT && idx_q == 2'd3) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            state_d      = S_READY;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = (state_q == S_INIT_WAIT) ? S_INIT_SEND : S_FR_SEND;
          end
        end else if (timer_q == TIMER_LAST) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_READY: begin
        if (accept) begin
          code_d = code_new;
          idx_d  = '0;
          // Launch word 0 straight from the fresh codes to save a cycle.
          if (!spi_busy) begin
            spi_start_d = 1'b1;
            spi_data_d  = frame_word(2'd0, code_new[0]);
            timer_d     = '0;
            state_d     = S_FR_WAIT;
          end else begin
            state_d = S_FR_SEND;
          end
        end
      end
      S_FR_SEND: begin
        if (!spi_busy) begin
          spi_start_d = 1'b1;
          spi_data_d  = frame_word(idx_q, code_q[idx_q]);
          timer_d     = '0;
          state_d     = S_FR_WAIT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_INIT_SEND;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT_SEND;
      idx_q        <= '0;
      timer_q      <= '0;
      spi_start_q  <= 1'b0;
      spi_data_q   <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      spi_start_q  <= spi_start_d;
      spi_data_q   <= spi_data_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
    end
  end

endmodule

// File: tb/tb_mems_dac_ctrl.sv
// Directed + randomized bench for mems_dac_ctrl with a reactive SPI master model
// and an arithmetic reference for the frame words.
module tb_mems_dac_ctrl;

  localparam int          TO    = 1023;
  localparam logic [23:0] I0    = 24'h280001;
  localparam logic [23:0] I1    = 24'h380001;
  localparam int          BIASI = 32768;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] x_in, y_in;
  logic        pos_valid;
  logic        pos_ready;
  logic [23:0] spi_data;
  logic        spi_start;
  logic        spi_busy;
  logic        spi_done;
  logic        init_done, frame_done, fault, busy;

  mems_dac_ctrl #(
    .BIAS(16'h8000), .INIT0(I0), .INIT1(I1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .x_in(x_in), .y_in(y_in),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .spi_data(spi_data),
    .spi_start(spi_start), .spi_busy(spi_busy), .spi_done(spi_done),
    .init_done(init_done), .frame_done(frame_done), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          fd_count = 0;
  int          n_starts = 0;
  int          start_cyc = 0;
  int          unstable = 0;
  int          resp_delay = 30;
  logic [23:0] words[$];

  initial forever begin
    @(posedge clk);
    cyc++;
    if (frame_done === 1'b1) fd_count++;
  end

  // SPI master model: logs each started word, checks it stays put, replies later.
  initial begin
    int          cnt;
    bit          pending;
    logic [23:0] held;
    spi_done = 1'b0;
    pending  = 0;
    cnt      = 0;
    held     = '0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (!rst_n) begin
        pending = 0;
      end else begin
        if (pending) begin
          if (spi_data !== held) unstable++;
          if (resp_delay != 0) begin
            cnt--;
            if (cnt == 0) begin
              spi_done = 1'b1;
              pending  = 0;
            end
          end
        end
        if (spi_start === 1'b1) begin
          words.push_back(spi_data);
          held      = spi_data;
          start_cyc = cyc;
          n_starts++;
          pending   = 1;
          cnt       = resp_delay;
        end
      end
    end
  end

  function automatic logic [23:0] exp_word(input int i, input logic [15:0] x, input logic [15:0] y);
    int v;
    int xs;
    int ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    case (i)
      0: v = BIASI + xs;
      1: v = BIASI - xs;
      2: v = BIASI + ys;
      default: v = BIASI - ys;
    endcase
    if (v < 0) v = 0;
    if (v > 65535) v = 65535;
    return {2'b00, (i == 3) ? 3'b010 : 3'b000, 3'(i), 16'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 500 && init_done !== 1'b1; i++) tick();
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_init_nwords"}, words.size(), 2);
    if (words.size() >= 2) begin
      chk({tag, "_init_word0"}, words[0], I0);
      chk({tag, "_init_word1"}, words[1], I1);
    end
    chk({tag, "_init_pos_ready"}, pos_ready, 1);
  endtask

  task automatic start_frame(input string tag, input logic [15:0] x, input logic [15:0] y);
    for (int i = 0; i < 500 && pos_ready !== 1'b1; i++) tick();
    chk({tag, "_ready_before"}, pos_ready, 1);
    words.delete();
    x_in = x;
    y_in = y;
    pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    if (spi_busy == 1'b0) chk({tag, "_first_start"}, spi_start, 1);
  endtask

  task automatic finish_frame(input string tag, input logic [15:0] x, input logic [15:0] y,
                              input int fd0);
    for (int i = 0; i < 2000 && fd_count == fd0; i++) tick();
    tick();
    tick();
    chk({tag, "_frame_done_pulses"}, fd_count - fd0, 1);
    chk({tag, "_nwords"}, words.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < words.size()) chk($sformatf("%s_word%0d", tag, i), words[i], exp_word(i, x, y));
    end
    chk({tag, "_busy_after"}, busy, 0);
    $display("frame %s x=%h y=%h words=%0d", tag, x, y, words.size());
  endtask

  task automatic run_frame(input string tag, input logic [15:0] x, input logic [15:0] y);
    int fd0;
    fd0 = fd_count;
    start_frame(tag, x, y);
    finish_frame(tag, x, y, fd0);
    chk({tag, "_ready_after"}, pos_ready, enable);
  endtask

  initial begin
    int fd0;
    int n0;
    int fault_cyc;
    logic [15:0] rx, ry;

    rst_n = 1'b0; enable = 1'b1; x_in = '0; y_in = '0; pos_valid = 1'b0; spi_busy = 1'b0;
    tick();
    tick();
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_pos_ready", pos_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 1);
    $display("reset values checked");

    words.delete();
    rst_n = 1'b1;
    wait_init("boot");

    // Mid-frame pos_valid with a different position must not disturb the frame.
    fd0 = fd_count;
    start_frame("dir1", 16'h1000, 16'hF000);
    x_in = 16'h1234; y_in = 16'h4321; pos_valid = 1'b1;
    repeat (5) tick();
    pos_valid = 1'b0;
    finish_frame("dir1", 16'h1000, 16'hF000, fd0);
    n0 = n_starts;
    repeat (5) tick();
    chk("dir1_no_queued_frame", n_starts - n0, 0);

    run_frame("clamp", 16'h7FFF, 16'h8000);
    run_frame("zero", 16'h0000, 16'h0000);
    run_frame("clamp2", 16'h8000, 16'h7FFF);

    for (int k = 0; k < 8; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      resp_delay = int'($urandom_range(1, 40));
      run_frame($sformatf("rnd%0d", k), rx, ry);
    end
    resp_delay = 30;

    // Enable dropped after the first word: frame still completes, then stays idle.
    fd0 = fd_count;
    start_frame("endrop", 16'h2345, 16'hDCBA);
    for (int i = 0; i < 500 && words.size() < 2; i++) tick();
    enable = 1'b0;
    finish_frame("endrop", 16'h2345, 16'hDCBA, fd0);
    repeat (3) tick();
    chk("endrop_ready_low", pos_ready, 0);
    enable = 1'b1;
    #1;
    chk("endrop_ready_back", pos_ready, 1);

    // spi_busy holds off the first word; then a reset lands during word 3.
    spi_busy = 1'b1;
    start_frame("bsy", 16'h0100, 16'hFF00);
    n0 = n_starts;
    repeat (50) tick();
    chk("bsy_no_start", n_starts - n0, 0);
    chk("bsy_busy_flag", busy, 1);
    spi_busy = 1'b0;
    tick();
    chk("bsy_start_after_release", spi_start, 1);
    for (int i = 0; i < 500 && words.size() < 3; i++) tick();
    chk("bsy_reached_word3", words.size(), 3);
    if (words.size() >= 1) chk("bsy_word0", words[0], exp_word(0, 16'h0100, 16'hFF00));
    rst_n = 1'b0;
    #1;
    chk("midrst_spi_start", spi_start, 0);
    chk("midrst_spi_data", spi_data, 0);
    chk("midrst_pos_ready", pos_ready, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_fault", fault, 0);
    tick();
    tick();
    words.delete();
    rst_n = 1'b1;
    wait_init("reboot");
    run_frame("post_rst", 16'hC000, 16'h4000);

    // SPI master goes silent: fault exactly TIMEOUT cycles after the start.
    resp_delay = 0;
    start_frame("tmo", 16'h0042, 16'h0024);
    for (int i = 0; i < TO + 50 && fault !== 1'b1; i++) tick();
    fault_cyc = cyc;
    chk("tmo_fault", fault, 1);
    chk("tmo_latency", fault_cyc - start_cyc, TO);
    n0 = n_starts;
    repeat (20) tick();
    chk("tmo_no_more_starts", n_starts - n0, 0);
    chk("tmo_spi_start", spi_start, 0);
    chk("tmo_pos_ready", pos_ready, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_fault_sticky", fault, 1);
    chk("spi_data_stable", unstable, 0);
    $display("timeout: fault after %0d cycles", fault_cyc - start_cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
